if_id_pipe_stage: RTL and testbench

- Parametrised next-generation IF/ID pipeline register for the MIPS pipeline.
- Captures PC+4 and the fetched instruction from IF, and presents pre-decoded fields to ID.
- Adds what the plain register lacks: a valid/ready handshake, flush for control hazards, an optional one-entry skid buffer so in_ready is a registered signal, and bubble (NOP) insertion.
- Sits between the instruction-memory/PC logic and the register file/control unit.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/if_id_skid_buf.sv | 78 +++++++
 rtl/if_id_pipe_stage.sv | 124 ++++++++++++
 tb/tb_if_id_pipe_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the IF/ID pipeline stage.
// Contents: opcode constants, the NOP word, instruction field bit
// positions and a 16-to-32 bit sign-extension helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JI_HI  = 25;
  localparam int JI_LO  = 0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/if_id_skid_buf.sv
// Generic two-entry valid/ready skid buffer.
// A main entry drives the output; a skid entry catches a beat that
// arrives while main is held. in_ready_o comes straight from a flop
// (!skid valid), so there is no combinational path from out_ready_i.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   flush_i             drop both entries; an incoming beat is discarded
//   in_valid_i/in_ready_o/in_data_i    upstream handshake and data
//   out_valid_o/out_ready_i/out_data_o downstream handshake and data
//   skid_valid_o        skid entry occupied (used for flush accounting)
module if_id_skid_buf #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         skid_valid_o
);

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         acc, deq;

  assign in_ready_o   = !skid_valid_q;
  assign out_valid_o  = main_valid_q;
  assign out_data_o   = main_data_q;
  assign skid_valid_o = skid_valid_q;

  assign acc = in_valid_i && !skid_valid_q && !flush_i;
  assign deq = main_valid_q && out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || deq) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so nothing arrives here
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = acc;
        if (acc) main_data_d = in_data_i;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register with valid/ready handshake, flush, optional
// skid buffer and bubble (NOP) insertion.
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid/in_ready          IF handshake; in_pc_plus_four, in_instruction
//   stall, flush, out_ready    ID-side hold, squash and consume
//   out_valid                  held beat valid
//   pc_plus_four .. jump_index decoded fields of the held instruction
//   flush_count                saturating count of squashed valid beats
module if_id_pipe_stage
  import mips_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int SKID_EN     = 1,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc_plus_four,
  input  logic [31:0]     in_instruction,
  input  logic            stall,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [PC_W-1:0] pc_plus_four,
  output logic [5:0]      op_code,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     immediate,
  output logic [31:0]     imm_sext,
  output logic [25:0]     jump_index,
  output logic [7:0]      flush_count
);

  localparam int DW = PC_W + 32;

  logic            cons_ready;
  logic            main_valid;
  logic [DW-1:0]   main_data;
  logic            skid_valid;
  logic [7:0]      flush_cnt_q, flush_cnt_d;
  logic [8:0]      flush_sum;
  logic            show;
  logic [31:0]     instr_vis;
  logic [PC_W-1:0] pc_vis;

  assign cons_ready = out_ready && !stall;

  if (SKID_EN != 0) begin : g_skid
    if_id_skid_buf #(.W(DW)) u_skid (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    ({in_pc_plus_four, in_instruction}),
      .out_ready_i  (cons_ready),
      .out_valid_o  (main_valid),
      .out_data_o   (main_data),
      .skid_valid_o (skid_valid)
    );
  end else begin : g_noskid
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          acc;

    assign in_ready   = !valid_q || cons_ready;
    assign acc        = in_valid && in_ready && !flush;
    assign main_valid = valid_q;
    assign main_data  = data_q;
    assign skid_valid = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (acc) begin
        valid_q <= 1'b1;
        data_q  <= {in_pc_plus_four, in_instruction};
      end else if (valid_q && cons_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Squashed beats are main + skid; the beat offered during flush is not counted.
  always_comb begin
    flush_sum   = {1'b0, flush_cnt_q} + 9'(main_valid) + 9'(skid_valid);
    flush_cnt_d = flush_cnt_q;
    if (flush) flush_cnt_d = flush_sum[8] ? 8'hFF : flush_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_cnt_q <= '0;
    else     flush_cnt_q <= flush_cnt_d;
  end

  assign out_valid   = main_valid;
  assign flush_count = flush_cnt_q;

  // Decode slices the stored word only; the bubble mask uses registered valid.
  assign show      = main_valid || (ZERO_BUBBLE == 0);
  assign instr_vis = show ? main_data[31:0] : NOP_WORD;
  assign pc_vis    = show ? main_data[DW-1:32] : '0;

  assign pc_plus_four = pc_vis;
  assign op_code      = instr_vis[OPC_HI:OPC_LO];
  assign rs           = instr_vis[RS_HI:RS_LO];
  assign rt           = instr_vis[RT_HI:RT_LO];
  assign rd           = instr_vis[RD_HI:RD_LO];
  assign shamt        = instr_vis[SH_HI:SH_LO];
  assign funct        = instr_vis[FN_HI:FN_LO];
  assign immediate    = instr_vis[IMM_HI:IMM_LO];
  assign imm_sext     = sext16(instr_vis[IMM_HI:IMM_LO]);
  assign jump_index   = instr_vis[JI_HI:JI_LO];

endmodule

// File: tb/tb_if_id_pipe_stage.sv
module tb_if_id_pipe_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] pc_plus_four, imm_sext;
  logic [5:0]  op_code, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [25:0] jump_index;
  logic [7:0]  flush_count;

  logic        in_valid_z, stall_z, flush_z, out_ready_z;
  logic [31:0] in_pc_z, in_instr_z;
  logic        in_ready_z, out_valid_z;
  logic [31:0] pc_z, imm_sext_z;
  logic [5:0]  op_code_z, funct_z;
  logic [4:0]  rs_z, rt_z, rd_z, shamt_z;
  logic [15:0] immediate_z;
  logic [25:0] jump_index_z;
  logic [7:0]  flush_count_z;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] e;
  int exp_fc;
  logic [5:0] ops[5];

  always #5 clk = ~clk;

  if_id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus_four(in_pc), .in_instruction(in_instr), .stall(stall),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .pc_plus_four(pc_plus_four), .op_code(op_code), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .immediate(immediate),
    .imm_sext(imm_sext), .jump_index(jump_index), .flush_count(flush_count)
  );

  if_id_pipe_stage #(.PC_W(32), .SKID_EN(0), .ZERO_BUBBLE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_z), .in_ready(in_ready_z),
    .in_pc_plus_four(in_pc_z), .in_instruction(in_instr_z), .stall(stall_z),
    .flush(flush_z), .out_ready(out_ready_z), .out_valid(out_valid_z),
    .pc_plus_four(pc_z), .op_code(op_code_z), .rs(rs_z), .rt(rt_z),
    .rd(rd_z), .shamt(shamt_z), .funct(funct_z), .immediate(immediate_z),
    .imm_sext(imm_sext_z), .jump_index(jump_index_z), .flush_count(flush_count_z)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs are stable at the falling edge, so the
  // handshakes seen here are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_fc = 0;
    end else begin
      check("sb_flush_count", 64'(flush_count), 64'(exp_fc));
      if (!out_valid)
        check("sb_bubble", 64'(|{pc_plus_four, op_code, rs, rt, rd, shamt, funct,
                                 immediate, imm_sext, jump_index}), 64'(0));
      if (flush) begin
        exp_fc = (exp_fc + sb.size() > 255) ? 255 : exp_fc + sb.size();
        sb.delete();
      end else begin
        if (out_valid && out_ready && !stall) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'(out_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            check("sb_pc", 64'(pc_plus_four), 64'(e[63:32]));
            check("sb_fields", 64'({op_code, rs, rt, rd, shamt, funct}), 64'(e[31:0]));
            check("sb_imm", 64'({immediate, imm_sext}), {e[15:0], {16{e[15]}}, e[15:0]});
            check("sb_jidx", 64'(jump_index), 64'(e[25:0]));
          end
        end
        if (in_valid && in_ready) sb.push_back({in_pc, in_instr});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW};
    rst = 1'b1;
    in_valid = 0; stall = 0; flush = 0; out_ready = 0; in_pc = 0; in_instr = 0;
    in_valid_z = 0; stall_z = 0; flush_z = 0; out_ready_z = 0; in_pc_z = 0; in_instr_z = 0;
    #22;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_flush_count", 64'(flush_count), 64'(0));
    check("rst_pc", 64'(pc_plus_four), 64'(0));
    @(posedge clk);
    #1;

    // back-to-back stream of lw $2,4($1)
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_pc = 32'(4 * i); in_instr = 32'h8C22_0004;
      step();
      check("stream_valid", 64'(out_valid), 64'(1));
      check("stream_pc", 64'(pc_plus_four), 64'(4 * i));
      if (i == 1) begin
        check("lw_op", 64'(op_code), 64'(OP_LW));
        check("lw_rs", 64'(rs), 64'(1));
        check("lw_rt", 64'(rt), 64'(2));
        check("lw_sext", 64'(imm_sext), 64'h0000_0004);
      end
    end
    in_valid = 0;
    step();
    check("stream_drained", 64'(out_valid), 64'(0));

    // beq with negative offset
    in_valid = 1; in_pc = 32'h14; in_instr = 32'h1000_FFFF;
    step();
    check("beq_op", 64'(op_code), 64'(OP_BEQ));
    check("beq_imm", 64'(immediate), 64'hFFFF);
    check("beq_sext", 64'(imm_sext), 64'hFFFF_FFFF);
    check("beq_jidx", 64'(jump_index), 64'h000_FFFF);
    in_valid = 0;
    step();

    // stall for three cycles while IF keeps pushing
    stall = 1; in_valid = 1; in_pc = 32'h11; in_instr = 32'h0022_1820;
    step();
    check("stall_pc_a", 64'(pc_plus_four), 64'h11);
    check("stall_rdy_a", 64'(in_ready), 64'(1));
    in_pc = 32'h22; in_instr = 32'h0043_2022;
    step();
    check("stall_pc_b", 64'(pc_plus_four), 64'h11);
    check("stall_rdy_b", 64'(in_ready), 64'(0));
    in_pc = 32'h33; in_instr = 32'h0800_0033;
    step();
    check("stall_pc_c", 64'(pc_plus_four), 64'h11);
    check("stall_rdy_c", 64'(in_ready), 64'(0));
    stall = 0;
    step();
    check("unstall_pc_22", 64'(pc_plus_four), 64'h22);
    check("unstall_rdy", 64'(in_ready), 64'(1));
    step();
    check("unstall_pc_33", 64'(pc_plus_four), 64'h33);
    in_valid = 0;
    step();
    check("unstall_drained", 64'(out_valid), 64'(0));

    // fill main and skid, then flush with a beat on the input
    out_ready = 0; in_valid = 1; in_pc = 32'h40; in_instr = {OP_SW, 5'd3, 5'd4, 16'h0010};
    step();
    in_pc = 32'h44; in_instr = {OP_J, 26'h3FF_FFFF};
    step();
    check("full_rdy", 64'(in_ready), 64'(0));
    in_pc = 32'h48; in_instr = 32'h8C22_0048; flush = 1;
    step();
    flush = 0; in_valid = 0;
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_rdy", 64'(in_ready), 64'(1));
    check("flush_pc_zero", 64'(pc_plus_four), 64'(0));
    check("flush_sext_zero", 64'(imm_sext), 64'(0));
    check("flush_count_2", 64'(flush_count), 64'(2));
    step();
    check("flush_dropped", 64'(out_valid), 64'(0));
    in_valid = 1; in_pc = 32'h4C; flush = 1;
    step();
    flush = 0; in_valid = 0;
    check("flush_empty_valid", 64'(out_valid), 64'(0));
    check("flush_empty_count", 64'(flush_count), 64'(2));

    // random traffic checked by the scoreboard
    for (int c = 0; c < 80; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_pc     = $urandom;
      in_instr  = $urandom;
      if (c % 3 == 0) in_instr[31:26] = ops[$urandom_range(0, 4)];
      stall     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 0; stall = 0; flush = 0; out_ready = 1;
    step();
    step();

    // async reset with skid full
    out_ready = 0; in_valid = 1; in_pc = 32'h50; in_instr = 32'h8C22_0050;
    step();
    in_pc = 32'h54;
    step();
    in_valid = 0;
    check("prerst_rdy", 64'(in_ready), 64'(0));
    #2;
    rst = 1;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_rdy", 64'(in_ready), 64'(1));
    check("arst_pc", 64'(pc_plus_four), 64'(0));
    check("arst_count", 64'(flush_count), 64'(0));
    @(posedge clk);
    #3;
    rst = 0;
    step();
    in_valid = 1; in_pc = 32'h60; in_instr = 32'h2000_0060; out_ready = 1;
    step();
    check("postrst_valid", 64'(out_valid), 64'(1));
    check("postrst_pc", 64'(pc_plus_four), 64'h60);
    in_valid = 0;
    step();
    check("postrst_drained", 64'(out_valid), 64'(0));

    // SKID_EN=0 build: combinational in_ready and flush saturation
    in_valid_z = 1; in_pc_z = 32'h70; in_instr_z = 32'h8C22_0004; out_ready_z = 1;
    step();
    check("z_valid", 64'(out_valid_z), 64'(1));
    check("z_pc", 64'(pc_z), 64'h70);
    in_valid_z = 0; out_ready_z = 0;
    #1;
    check("z_rdy_low", 64'(in_ready_z), 64'(0));
    out_ready_z = 1;
    #1;
    check("z_rdy_high", 64'(in_ready_z), 64'(1));
    stall_z = 1;
    #1;
    check("z_rdy_stall", 64'(in_ready_z), 64'(0));
    stall_z = 0;
    step();
    check("z_drained", 64'(out_valid_z), 64'(0));
    out_ready_z = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid_z = 1; flush_z = 0; in_pc_z = 32'(i);
      step();
      in_valid_z = 0; flush_z = 1;
      step();
      flush_z = 0;
      if (i == 0)   check("z_fc_1", 64'(flush_count_z), 64'(1));
      if (i == 253) check("z_fc_254", 64'(flush_count_z), 64'(254));
      if (i == 254) check("z_fc_255", 64'(flush_count_z), 64'(255));
    end
    check("z_fc_sat", 64'(flush_count_z), 64'(255));
    check("z_flush_valid", 64'(out_valid_z), 64'(0));
    check("z_flush_pc", 64'(pc_z), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
